// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The cache takes the slave view; the datapath/controller side takes the master view.
interface icache_direct_if;
    // datapath fetch port
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    // memory controller instruction port
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, one-word fill on miss,
// whole-cache flush and hit/miss statistics counters.
module icache_direct #(
    parameter int SETS = 16,
    parameter int IDXW = $clog2(SETS),
    parameter int TAGW = 30 - IDXW
) (
    input  logic              CLK,
    input  logic              RST,
    icache_direct_if.slave    bus,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]      state;
    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tag_mem  [SETS];
    logic [31:0]     data_mem [SETS];
    logic [31:2]     miss_addr;

    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic [IDXW-1:0] miss_idx;
    logic [TAGW-1:0] miss_tag;
    logic            match;
    logic            fill;
    logic            unused_addr_bits;

    assign idx      = bus.imemaddr[IDXW+1:2];
    assign tag      = bus.imemaddr[31:IDXW+2];
    assign miss_idx = miss_addr[IDXW+1:2];
    assign miss_tag = miss_addr[31:IDXW+2];
    assign unused_addr_bits = ^bus.imemaddr[1:0];

    // A flush in the same cycle as the returning word wins: the fill is dropped.
    assign fill = (state == FETCH) && !bus.iwait && !bus.flush;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        match        = 1'b0;
        bus.imemload = '0;
        if (state == IDLE && bus.imemREN && valid[idx] && tag_mem[idx] == tag) begin
            match        = 1'b1;
            bus.imemload = data_mem[idx];
        end
    end

    assign bus.ihit  = match;
    assign bus.iREN  = (state == FETCH);
    assign bus.iaddr = {miss_addr, 2'b00};

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (match) begin
                hit_count <= hit_count + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.imemREN && !match && !bus.flush) begin
                        miss_addr  <= bus.imemaddr[31:2];
                        miss_count <= miss_count + 32'd1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.flush || !bus.iwait) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (fill) begin
                valid[miss_idx] <= 1'b1;
            end
            // Placed last so a flush clears the whole array regardless of the line above.
            if (bus.flush) begin
                valid <= '0;
            end
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge CLK) begin
        if (!RST && fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: miss/fill timing, hits, eviction, redirect during
// fetch, flush in FETCH and IDLE, and reset during FETCH.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    int          total = 0;
    int          bad   = 0;

    icache_direct_if bus ();

    icache_direct dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1ns after the edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST          = 1'b1;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.flush    = 1'b0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        next_cycle();
        next_cycle();
        RST = 1'b0;
        #1;
        check("rst_ihit",     {31'd0, bus.ihit}, 32'd0);
        check("rst_imemload", bus.imemload,      32'd0);
        check("rst_iREN",     {31'd0, bus.iREN}, 32'd0);
        check("rst_iaddr",    bus.iaddr,         32'd0);
        check("rst_hits",     hit_count,         32'd0);
        check("rst_misses",   miss_count,        32'd0);

        // Cold miss on 0x40, memory stalls for two cycles.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0040;
        bus.iload    = 32'hDEAD_BEEF;
        #1;
        check("cold_miss_ihit", {31'd0, bus.ihit}, 32'd0);
        check("cold_miss_iREN", {31'd0, bus.iREN}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.iwait = (k < 2) ? 1'b1 : 1'b0;
            #1;
            check("fetch_iREN",  {31'd0, bus.iREN}, 32'd1);
            check("fetch_iaddr", bus.iaddr,         32'h0000_0040);
            check("fetch_ihit",  {31'd0, bus.ihit}, 32'd0);
        end
        next_cycle();
        bus.iwait = 1'b1;
        #1;
        check("fill_ihit",   {31'd0, bus.ihit}, 32'd1);
        check("fill_data",   bus.imemload,      32'hDEAD_BEEF);
        check("fill_misses", miss_count,        32'd1);
        check("fill_hits",   hit_count,         32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check("hold_ihit", {31'd0, bus.ihit}, 32'd1);
            check("hold_iREN", {31'd0, bus.iREN}, 32'd0);
        end
        next_cycle();
        check("hold_hits", hit_count, 32'd5);

        // Conflict: 0x80 evicts 0x40, then 0x40 is refetched.
        bus.imemaddr = 32'h0000_0080;
        bus.iload    = 32'h1234_5678;
        bus.iwait    = 1'b0;
        #1;
        check("conf_miss_ihit", {31'd0, bus.ihit}, 32'd0);
        next_cycle();
        check("conf_iaddr", bus.iaddr, 32'h0000_0080);
        next_cycle();
        check("conf_ihit", {31'd0, bus.ihit}, 32'd1);
        check("conf_data", bus.imemload,      32'h1234_5678);
        bus.imemaddr = 32'h0000_0040;
        #1;
        check("evicted_ihit", {31'd0, bus.ihit}, 32'd0);
        next_cycle();
        bus.iload = 32'hDEAD_BEEF;
        #1;
        check("refetch_iaddr",  bus.iaddr,  32'h0000_0040);
        check("refetch_misses", miss_count, 32'd3);
        next_cycle();
        check("refetch_data", bus.imemload, 32'hDEAD_BEEF);

        // Redirect during FETCH: 0x100 still fills, 0x04 misses afterwards.
        bus.imemaddr = 32'h0000_0100;
        bus.iload    = 32'hCAFE_F00D;
        bus.iwait    = 1'b1;
        next_cycle();
        bus.imemaddr = 32'h0000_0004;
        bus.iwait    = 1'b0;
        #1;
        check("redir_iaddr", bus.iaddr,         32'h0000_0100);
        check("redir_ihit",  {31'd0, bus.ihit}, 32'd0);
        next_cycle();
        check("redir_idle_iREN", {31'd0, bus.iREN}, 32'd0);
        check("redir_idle_ihit", {31'd0, bus.ihit}, 32'd0);
        next_cycle();
        bus.iload = 32'hA5A5_A5A5;
        #1;
        check("redir2_iaddr",  bus.iaddr,  32'h0000_0004);
        check("redir2_misses", miss_count, 32'd5);
        next_cycle();
        check("redir2_data", bus.imemload, 32'hA5A5_A5A5);
        bus.imemaddr = 32'h0000_0100;
        #1;
        check("redir_kept_ihit", {31'd0, bus.ihit}, 32'd1);
        check("redir_kept_data", bus.imemload,      32'hCAFE_F00D);

        // Flush in FETCH together with iwait=0: no fill, all lines invalid.
        bus.imemaddr = 32'h0000_0200;
        next_cycle();
        bus.flush = 1'b1;
        bus.iload = 32'h1111_1111;
        #1;
        check("flush_iREN_before", {31'd0, bus.iREN}, 32'd1);
        next_cycle();
        bus.flush = 1'b0;
        bus.iwait = 1'b1;
        #1;
        check("flush_iREN_after", {31'd0, bus.iREN}, 32'd0);
        check("flush_ihit_200",   {31'd0, bus.ihit}, 32'd0);
        bus.imemaddr = 32'h0000_0100;
        #1;
        check("flush_ihit_100", {31'd0, bus.ihit}, 32'd0);
        bus.imemaddr = 32'h0000_0004;
        #1;
        check("flush_ihit_004", {31'd0, bus.ihit}, 32'd0);
        check("flush_misses",   miss_count,        32'd6);

        // Reset during FETCH.
        next_cycle();
        check("prerst_iREN",  {31'd0, bus.iREN}, 32'd1);
        check("prerst_iaddr", bus.iaddr,         32'h0000_0004);
        RST = 1'b1;
        next_cycle();
        RST         = 1'b0;
        bus.imemREN = 1'b0;
        #1;
        check("midrst_iREN",   {31'd0, bus.iREN}, 32'd0);
        check("midrst_hits",   hit_count,         32'd0);
        check("midrst_misses", miss_count,        32'd0);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0100;
        bus.flush    = 1'b1;
        #1;
        check("postrst_ihit_100", {31'd0, bus.ihit}, 32'd0);
        // Flush in IDLE suppresses the miss.
        next_cycle();
        bus.flush = 1'b0;
        bus.imemREN = 1'b0;
        #1;
        check("idle_flush_iREN",   {31'd0, bus.iREN}, 32'd0);
        check("idle_flush_misses", miss_count,        32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
